// File: rtl/midi_tx.sv
// ---------------------------------------------------------------------------
// midi_tx
//
// Serial MIDI transmitter. A note event (note on/off, channel, key number,
// velocity) is captured on a send strobe. It is shifted out on a UART line as
// a 3-byte MIDI channel-voice message: status, data1, data2. Each byte is
// framed as 1 start bit, 8 data bits LSB first and 1 stop bit. Every bit lasts
// CLKS_PER_BIT clocks. The default of 2080 clocks gives 31250 baud from the
// 65 MHz system clock.
//
// With RUNNING_STATUS=1, the status byte is left out when it matches the last
// status byte that went out on the line. The message is then only 2 bytes.
//
// Ports:
//   clock      in   65 MHz system clock, single clock domain
//   reset      in   synchronous, active-high
//   send       in   request strobe, accepted only while busy is low
//   note_on    in   1 = Note On (0x9n), 0 = Note Off (0x8n)
//   channel    in   MIDI channel n, 0..15
//   key_index  in   note number, sent as data byte 1
//   velocity   in   velocity, sent as data byte 2
//   serial     out  UART TX line, idle high, driven straight from a flop
//   busy       out  high while a message is on the line
//   done       out  one-cycle pulse after the last stop bit completes
// ---------------------------------------------------------------------------
module midi_tx #(
  parameter int CLKS_PER_BIT   = 2080,
  parameter int CNT_W          = 12,
  parameter int RUNNING_STATUS = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       send,
  input  logic       note_on,
  input  logic [3:0] channel,
  input  logic [6:0] key_index,
  input  logic [6:0] velocity,
  output logic       serial,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [1:0]       byte_idx;
  logic [7:0]       shift_reg;
  logic [7:0]       data1_r;
  logic [7:0]       data2_r;
  logic [7:0]       last_status;
  logic             last_valid;

  logic [7:0]       status_in;
  logic             skip_status;
  logic             bit_end;

  // Status byte for the event on the inputs. The status byte is skipped only
  // when running status is enabled and the same status byte has already gone
  // out since the last reset.
  always_comb begin
    status_in   = {1'b1, 2'b00, note_on, channel};
    skip_status = (RUNNING_STATUS != 0) && last_valid && (status_in == last_status);
    bit_end     = (bit_cnt == BIT_LAST);
  end

  // Transmit state machine. All outputs are registered, so serial never
  // glitches.
  // byte_idx 0/1/2 selects status/data1/data2. A running-status message
  // starts at index 1.
  // The DONE state doubles as an idle cycle, so a held send restarts there.
  // That leaves exactly one idle-high cycle between back-to-back messages.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      serial      <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      bit_cnt     <= '0;
      bit_idx     <= '0;
      byte_idx    <= '0;
      shift_reg   <= '0;
      data1_r     <= '0;
      data2_r     <= '0;
      last_status <= '0;
      last_valid  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state  <= IDLE;
          serial <= 1'b1;
          busy   <= 1'b0;
          if (send) begin
            // Bit 7 of both data bytes is forced low.
            data1_r <= {1'b0, key_index};
            data2_r <= {1'b0, velocity};
            bit_cnt <= '0;
            bit_idx <= '0;
            serial  <= 1'b0;
            busy    <= 1'b1;
            state   <= START;
            if (skip_status) begin
              shift_reg <= {1'b0, key_index};
              byte_idx  <= 2'd1;
            end else begin
              shift_reg   <= status_in;
              byte_idx    <= 2'd0;
              last_status <= status_in;
              last_valid  <= 1'b1;
            end
          end
        end

        START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            serial  <= shift_reg[0];
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end

        // The shift register is pre-shifted, so the next bit to send is always
        // at index 1 when a bit period ends.
        DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              serial <= 1'b1;
              state  <= STOP;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              shift_reg <= {1'b0, shift_reg[7:1]};
              serial    <= shift_reg[1];
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (byte_idx == 2'd2) begin
              serial <= 1'b1;
              busy   <= 1'b0;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              byte_idx  <= byte_idx + 2'd1;
              shift_reg <= (byte_idx == 2'd0) ? data1_r : data2_r;
              serial    <= 1'b0;
              state     <= START;
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end

        default: begin
          state  <= IDLE;
          serial <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_midi_tx.sv
// ---------------------------------------------------------------------------
// tb_midi_tx
//
// Three transmitter lanes share one clock. Each lane has its own reset and
// its own inputs:
//   lane 0: CLKS_PER_BIT=4,    RUNNING_STATUS=0
//   lane 1: CLKS_PER_BIT=4,    RUNNING_STATUS=1
//   lane 2: CLKS_PER_BIT=2080, RUNNING_STATUS=0
// Stimulus pushes hand-computed line bytes and busy lengths into per-lane
// queues. A per-lane UART decoder and a busy/done monitor pop from those
// queues and compare them with what appears on the pins.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_midi_tx;

  logic       clock;
  logic       rst_s     [3];
  logic       send_s    [3];
  logic       note_on_s [3];
  logic [3:0] chan_s    [3];
  logic [6:0] key_s     [3];
  logic [6:0] vel_s     [3];
  logic       ser_s     [3];
  logic       busy_s    [3];
  logic       done_s    [3];

  logic [7:0] exp_bytes [3][$];
  int         exp_dur   [3][$];

  int checks = 0;
  int errors = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Every comparison goes through here, so the counters stay in one place.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic pushExpect(input int i, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input int nbytes, input int dur);
    exp_bytes[i].push_back(b0);
    exp_bytes[i].push_back(b1);
    if (nbytes == 3) exp_bytes[i].push_back(b2);
    exp_dur[i].push_back(dur);
  endtask

  // Queue the expected message, then present the event and pulse send for
  // one clock. Returns just after the edge that accepted the event.
  task automatic applyStimulus(input int i, input logic on, input logic [3:0] ch,
                               input logic [6:0] key, input logic [6:0] vel,
                               input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input int nbytes, input int dur);
    pushExpect(i, b0, b1, b2, nbytes, dur);
    @(posedge clock);
    #1;
    note_on_s[i] = on;
    chan_s[i]    = ch;
    key_s[i]     = key;
    vel_s[i]     = vel;
    send_s[i]    = 1'b1;
    @(posedge clock);
    #1;
    send_s[i] = 1'b0;
  endtask

  task automatic waitDone(input int i, input int budget);
    int n;
    n = 0;
    while (!done_s[i] && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (!done_s[i]) begin
      checks++;
      errors++;
      $display("[TB] FAIL lane%0d_done_timeout: got no done within %0d cycles, expected a done pulse", i, budget);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int CPB = (g == 2) ? 2080 : 4;
    localparam int RS  = (g == 1) ? 1 : 0;

    midi_tx #(
      .CLKS_PER_BIT  (CPB),
      .CNT_W         (12),
      .RUNNING_STATUS(RS)
    ) dut (
      .clock    (clock),
      .reset    (rst_s[g]),
      .send     (send_s[g]),
      .note_on  (note_on_s[g]),
      .channel  (chan_s[g]),
      .key_index(key_s[g]),
      .velocity (vel_s[g]),
      .serial   (ser_s[g]),
      .busy     (busy_s[g]),
      .done     (done_s[g])
    );

    // UART decoder. It finds the first low cycle of a start bit, then samples
    // each bit mid-period. A frame cut short by reset is thrown away.
    initial begin : decoder
      logic [7:0] rx;
      logic       stop_bit;
      bit         aborted;
      int         wait_n;
      forever begin
        @(negedge clock);
        if (!rst_s[g] && ser_s[g] == 1'b0) begin
          aborted  = 1'b0;
          rx       = '0;
          stop_bit = 1'b0;
          for (int j = 0; j < 9; j++) begin
            wait_n = (j == 0) ? CPB + CPB / 2 : CPB;
            for (int c = 0; c < wait_n; c++) begin
              @(negedge clock);
              if (rst_s[g]) aborted = 1'b1;
            end
            if (aborted) break;
            if (j < 8) rx[j] = ser_s[g];
            else       stop_bit = ser_s[g];
          end
          if (!aborted) begin
            checkOutput($sformatf("lane%0d_stop_bit", g), int'(stop_bit), 1);
            if (exp_bytes[g].size() == 0) begin
              checks++;
              errors++;
              $display("[TB] FAIL lane%0d_unexpected_byte: got 0x%0h, expected no byte", g, rx);
            end else begin
              checkOutput($sformatf("lane%0d_line_byte", g), int'(rx), int'(exp_bytes[g].pop_front()));
            end
          end
        end
      end
    end

    // This monitor checks four things:
    //   - busy rises together with the start bit;
    //   - transitions inside a message fall on bit-period boundaries;
    //   - done appears exactly on the cycle busy falls;
    //   - busy lasts the expected number of cycles.
    initial begin : busy_mon
      int   cnt;
      int   cyc;
      int   last_edge;
      logic prev_busy;
      logic prev_ser;
      logic fall;
      int   want;
      cnt = 0; cyc = 0; last_edge = 0; prev_busy = 1'b0; prev_ser = 1'b1;
      forever begin
        @(negedge clock);
        cyc++;
        if (rst_s[g]) begin
          cnt       = 0;
          prev_busy = 1'b0;
          prev_ser  = 1'b1;
        end else begin
          fall = prev_busy && !busy_s[g];
          if (busy_s[g] && !prev_busy)
            checkOutput($sformatf("lane%0d_start_bit_with_busy", g), int'(ser_s[g]), 0);
          if (ser_s[g] != prev_ser) begin
            if (prev_busy)
              checkOutput($sformatf("lane%0d_bit_period", g), (cyc - last_edge) % CPB, 0);
            last_edge = cyc;
          end
          if (done_s[g] || fall)
            checkOutput($sformatf("lane%0d_done_at_busy_fall", g), int'(done_s[g]), int'(fall));
          if (fall) begin
            if (exp_dur[g].size() == 0) begin
              checks++;
              errors++;
              $display("[TB] FAIL lane%0d_unexpected_message: got busy for %0d cycles, expected no message", g, cnt);
            end else begin
              want = exp_dur[g].pop_front();
              checkOutput($sformatf("lane%0d_busy_cycles", g), cnt, want);
            end
            cnt = 0;
          end
          if (busy_s[g]) cnt++;
          prev_busy = busy_s[g];
          prev_ser  = ser_s[g];
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish by 1 ms, expected the run to end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    for (int i = 0; i < 3; i++) begin
      rst_s[i] = 1'b1; send_s[i] = 1'b0; note_on_s[i] = 1'b0;
      chan_s[i] = '0; key_s[i] = '0; vel_s[i] = '0;
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("lane%0d_reset_serial", i), int'(ser_s[i]), 1);
      checkOutput($sformatf("lane%0d_reset_busy", i), int'(busy_s[i]), 0);
      checkOutput($sformatf("lane%0d_reset_done", i), int'(done_s[i]), 0);
    end
    @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) rst_s[i] = 1'b0;

    // Basic Note On, 3 bytes in 120 cycles.
    $display("[TB] plain note on");
    applyStimulus(0, 1'b1, 4'd0, 7'h3C, 7'h64, 8'h90, 8'h3C, 8'h64, 3, 120);
    waitDone(0, 200);
    checkOutput("t1_serial_idle_at_done", int'(ser_s[0]), 1);
    @(negedge clock);
    checkOutput("t1_done_one_cycle", int'(done_s[0]), 0);
    checkOutput("t1_serial_idle_after", int'(ser_s[0]), 1);
    checkOutput("t1_busy_low_after", int'(busy_s[0]), 0);

    // Running status: the repeated status byte is dropped; a new one is sent.
    $display("[TB] running status");
    applyStimulus(1, 1'b1, 4'd2, 7'h40, 7'h10, 8'h92, 8'h40, 8'h10, 3, 120);
    waitDone(1, 200);
    applyStimulus(1, 1'b1, 4'd2, 7'h43, 7'h10, 8'h43, 8'h10, 8'h00, 2, 80);
    waitDone(1, 200);
    applyStimulus(1, 1'b0, 4'd2, 7'h40, 7'h00, 8'h82, 8'h40, 8'h00, 3, 120);
    waitDone(1, 200);

    // A send while busy is dropped, and the latched data is kept.
    $display("[TB] send while busy");
    applyStimulus(0, 1'b1, 4'd5, 7'h30, 7'h20, 8'h95, 8'h30, 8'h20, 3, 120);
    repeat (9) @(posedge clock);
    #1;
    note_on_s[0] = 1'b0; chan_s[0] = 4'd9; key_s[0] = 7'h7E; vel_s[0] = 7'h01;
    send_s[0] = 1'b1;
    @(posedge clock);
    #1;
    send_s[0] = 1'b0;
    waitDone(0, 200);
    repeat (40) @(negedge clock);
    checkOutput("t3_no_second_message", int'(busy_s[0]), 0);

    // Reset mid-message clears the line and the running-status memory.
    $display("[TB] reset mid message");
    applyStimulus(1, 1'b0, 4'd2, 7'h41, 7'h22, 8'h41, 8'h22, 8'h00, 2, 80);
    repeat (49) @(posedge clock);
    #1;
    rst_s[1] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checkOutput("t4_reset_serial", int'(ser_s[1]), 1);
    checkOutput("t4_reset_busy", int'(busy_s[1]), 0);
    checkOutput("t4_reset_done", int'(done_s[1]), 0);
    exp_bytes[1].delete();
    exp_dur[1].delete();
    @(posedge clock);
    #1;
    rst_s[1] = 1'b0;
    applyStimulus(1, 1'b0, 4'd2, 7'h41, 7'h22, 8'h82, 8'h41, 8'h22, 3, 120);
    waitDone(1, 200);

    // Holding send gives back-to-back messages with a one-cycle gap.
    // The inputs change during the first message, so the next accept
    // latches the new event.
    $display("[TB] send held high");
    pushExpect(0, 8'h97, 8'h11, 8'h22, 3, 120);
    pushExpect(0, 8'h83, 8'h55, 8'h01, 3, 120);
    pushExpect(0, 8'h83, 8'h55, 8'h01, 3, 120);
    @(posedge clock);
    #1;
    note_on_s[0] = 1'b1; chan_s[0] = 4'd7; key_s[0] = 7'h11; vel_s[0] = 7'h22;
    send_s[0] = 1'b1;
    @(posedge clock);
    #1;
    note_on_s[0] = 1'b0; chan_s[0] = 4'd3; key_s[0] = 7'h55; vel_s[0] = 7'h01;
    waitDone(0, 200);
    checkOutput("t6_gap_serial_high", int'(ser_s[0]), 1);
    @(negedge clock);
    checkOutput("t6_restart_busy", int'(busy_s[0]), 1);
    checkOutput("t6_restart_start_bit", int'(ser_s[0]), 0);
    waitDone(0, 200);
    @(posedge clock);
    #1;
    send_s[0] = 1'b0;
    waitDone(0, 200);
    repeat (20) @(negedge clock);
    checkOutput("t6_stops_after_release", int'(busy_s[0]), 0);

    // Full-rate timing: 2080 clocks per bit, 62400 clocks per message.
    $display("[TB] full rate note off");
    applyStimulus(2, 1'b0, 4'd15, 7'h7F, 7'h00, 8'h8F, 8'h7F, 8'h00, 3, 62400);
    waitDone(2, 70000);

    repeat (20) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("lane%0d_bytes_outstanding", i), exp_bytes[i].size(), 0);
      checkOutput($sformatf("lane%0d_messages_outstanding", i), exp_dur[i].size(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
